// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the FFT stage controller and its
// address generator.
//   FFT_N   default transform size (power of two)
//   FFT_AW  data RAM address width for FFT_N
//   TW_ONE  twiddle value representing 1.0; the butterfly rescales products
//           with >>>10, so ROM entries are round(TW_ONE*cos), round(-TW_ONE*sin)
//   state_t controller state encoding
package fft_pkg;

    localparam int FFT_N  = 16;
    localparam int FFT_AW = $clog2(FFT_N);
    localparam int TW_ONE = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: combinational address map for an in-place radix-2 DIF FFT.
//   s        in   stage index
//   k        in   butterfly index within the stage, 0..N/2-1
//   addr_a   out  upper-leg address  g*2*span + j
//   addr_b   out  lower-leg address  addr_a + span
//   tw_addr  out  twiddle index      j << s
// where span = N >> (s+1), j = k mod span, g = k / span.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int  N  = FFT_N,
    localparam int AW = $clog2(N),
    localparam int SW = $clog2(AW + 1)
) (
    input  logic [SW-1:0] s,
    input  logic [AW-2:0] k,
    output logic [AW-1:0] addr_a,
    output logic [AW-1:0] addr_b,
    output logic [AW-2:0] tw_addr
);

    localparam logic [AW-1:0] HALF = AW'(N / 2);

    logic [AW-1:0] span;
    logic [AW-1:0] mask;
    logic [AW-1:0] kx;

    // span is a power of two, so k mod span is k & mask and g*span is
    // k & ~mask; doubling that group offset leaves room for the lower leg.
    always_comb begin
        span    = HALF >> s;
        mask    = span - AW'(1);
        kx      = {1'b0, k};
        addr_a  = ((kx & ~mask) << 1) | (kx & mask);
        addr_b  = addr_a | span;
        tw_addr = (k & mask[AW-2:0]) << s;
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequencer for an in-place radix-2 DIF FFT of N points
// around a single combinational butterfly. Input in natural order, result
// left in bit-reversed order.
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 transform request, sampled only in IDLE
//   busy                  high in RUN, DRAIN and DONE
//   done                  one-cycle pulse after the final stage's last write
//   rd_en, rd_addr_a/b    RAM read strobe and leg addresses (one per RUN cycle)
//   tw_addr               twiddle ROM index k for W = exp(-j2*pi*k/N)
//   wr_en, wr_addr_a/b    read strobe/addresses delayed by RD_LAT cycles
//   stage                 current stage s (0 outside RUN/DRAIN)
//   fsm_state             controller state, for observation
//
// Handshake: start is a level that is only looked at in IDLE; a start seen
// there is accepted on that clock edge, busy rises in the following cycle and
// stays high until the done cycle; start while busy is dropped, not queued.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int  N      = FFT_N,
    parameter int  RD_LAT = 1,
    localparam int AW     = $clog2(N),
    localparam int SW     = $clog2(AW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-2:0] tw_addr,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic [SW-1:0] stage,
    output state_t        fsm_state
);

    localparam int            DW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-2:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(AW - 1);
    localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

    state_t        state, state_nxt;
    logic [SW-1:0] s_q, s_nxt;
    logic [AW-2:0] k_q, k_nxt;
    logic [DW-1:0] d_q, d_nxt;

    logic          run;
    logic [AW-1:0] gen_a, gen_b;
    logic [AW-2:0] gen_tw;

    // Read-to-write delay line; flushed by reset so no stale write escapes.
    logic          v_q [RD_LAT];
    logic [AW-1:0] a_q [RD_LAT];
    logic [AW-1:0] b_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s_q   <= '0;
            k_q   <= '0;
            d_q   <= '0;
        end else begin
            state <= state_nxt;
            s_q   <= s_nxt;
            k_q   <= k_nxt;
            d_q   <= d_nxt;
        end
    end

    // DRAIN holds off the next stage for RD_LAT cycles so that the last write
    // of stage s lands before the first read of stage s+1.
    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        k_nxt     = k_q;
        d_nxt     = d_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    s_nxt     = '0;
                    k_nxt     = '0;
                    d_nxt     = '0;
                end
            end
            RUN: begin
                k_nxt = k_q + (AW-1)'(1);
                if (k_q == K_LAST) begin
                    state_nxt = DRAIN;
                    k_nxt     = '0;
                    d_nxt     = '0;
                end
            end
            DRAIN: begin
                d_nxt = d_q + DW'(1);
                if (d_q == D_LAST) begin
                    d_nxt = '0;
                    if (s_q == S_LAST) begin
                        state_nxt = DONE;
                        s_nxt     = '0;
                    end else begin
                        state_nxt = RUN;
                        s_nxt     = s_q + SW'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                s_nxt     = '0;
                k_nxt     = '0;
                d_nxt     = '0;
            end
        endcase
    end

    fft_addr_gen #(.N(N)) u_addr_gen (
        .s       (s_q),
        .k       (k_q),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_tw)
    );

    assign run       = (state == RUN);
    assign rd_en     = run;
    assign rd_addr_a = run ? gen_a  : '0;
    assign rd_addr_b = run ? gen_b  : '0;
    assign tw_addr   = run ? gen_tw : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign stage     = (state == RUN || state == DRAIN) ? s_q : '0;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            v_q[0] <= rd_en;
            a_q[0] <= rd_addr_a;
            b_q[0] <= rd_addr_b;
            for (int i = 1; i < RD_LAT; i++) begin
                v_q[i] <= v_q[i-1];
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
        end
    end

    assign wr_en     = v_q[RD_LAT-1];
    assign wr_addr_a = a_q[RD_LAT-1];
    assign wr_addr_b = b_q[RD_LAT-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// tb_fft_stage_ctrl: bench for fft_stage_ctrl with two instances
// (N=8/RD_LAT=1 and N=16/RD_LAT=3), a per-cycle scoreboard built from the
// address formulas, and a small RAM/ROM/butterfly model for end-to-end runs.
module tb_fft_stage_ctrl;
    import fft_pkg::*;

    localparam int EW = 58;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic start8, start16;

    logic       busy8, done8, rd8, wr8;
    logic [2:0] ra8, rb8, wa8, wb8;
    logic [1:0] tw8, stg8;
    state_t     fs8;

    logic       busy16, done16, rd16, wr16;
    logic [3:0] ra16, rb16, wa16, wb16;
    logic [2:0] tw16, stg16;
    state_t     fs16;

    fft_stage_ctrl #(.N(8), .RD_LAT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
        .rd_en(rd8), .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_addr(tw8),
        .wr_en(wr8), .wr_addr_a(wa8), .wr_addr_b(wb8), .stage(stg8),
        .fsm_state(fs8)
    );

    fft_stage_ctrl #(.N(16), .RD_LAT(3)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16),
        .rd_en(rd16), .rd_addr_a(ra16), .rd_addr_b(rb16), .tw_addr(tw16),
        .wr_en(wr16), .wr_addr_a(wa16), .wr_addr_b(wb16), .stage(stg16),
        .fsm_state(fs16)
    );

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;
    int m_busy, m_done, m_rd, m_ra, m_rb, m_tw, m_stg, m_wr, m_wa, m_wb, m_fsm;

    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sample_outs();
        if (sel == 1) begin
            m_busy = int'(busy16); m_done = int'(done16); m_rd = int'(rd16);
            m_ra = int'(ra16); m_rb = int'(rb16); m_tw = int'(tw16);
            m_stg = int'(stg16); m_wr = int'(wr16); m_wa = int'(wa16);
            m_wb = int'(wb16); m_fsm = int'(fs16);
        end else begin
            m_busy = int'(busy8); m_done = int'(done8); m_rd = int'(rd8);
            m_ra = int'(ra8); m_rb = int'(rb8); m_tw = int'(tw8);
            m_stg = int'(stg8); m_wr = int'(wr8); m_wa = int'(wa8);
            m_wb = int'(wb8); m_fsm = int'(fs8);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) start16 = v;
        else start8 = v;
    endtask

    task automatic check_all_zero(input string pfx);
        sample_outs();
        check({pfx, "_busy"}, m_busy, 0);
        check({pfx, "_done"}, m_done, 0);
        check({pfx, "_rd_en"}, m_rd, 0);
        check({pfx, "_rd_a"}, m_ra, 0);
        check({pfx, "_rd_b"}, m_rb, 0);
        check({pfx, "_tw"}, m_tw, 0);
        check({pfx, "_stage"}, m_stg, 0);
        check({pfx, "_wr_en"}, m_wr, 0);
        check({pfx, "_wr_a"}, m_wa, 0);
        check({pfx, "_wr_b"}, m_wb, 0);
        check({pfx, "_state"}, m_fsm, int'(IDLE));
    endtask

    function automatic logic [EW-1:0] pack_exp(input int rd, input int a, input int b,
                                               input int tw, input int st, input int bz,
                                               input int dn, input int wr, input int wa,
                                               input int wb);
        return {rd[0], a[9:0], b[9:0], tw[9:0], st[3:0], bz[0], dn[0], wr[0], wa[9:0], wb[9:0]};
    endfunction

    // Expected per-cycle outputs, sample 0 being the cycle after the accepting
    // edge: stage by stage, N/2 butterflies then RD_LAT drain cycles, then the
    // done cycle and one idle cycle. Writes are the reads RD_LAT cycles earlier.
    task automatic build_expected(input int n, input int lat);
        int rde[128], ra[128], rb[128], rt[128], rs[128];
        int nst, total, idx, span, j, g, a, wr, wa, wb;
        nst = $clog2(n);
        total = nst * (n / 2 + lat);
        idx = 0;
        exp_q.delete();
        for (int s = 0; s < nst; s++) begin
            span = n >> (s + 1);
            for (int k = 0; k < n / 2; k++) begin
                j = k % span;
                g = k / span;
                a = g * 2 * span + j;
                rde[idx] = 1; ra[idx] = a; rb[idx] = a + span; rt[idx] = j << s; rs[idx] = s;
                idx++;
            end
            for (int d = 0; d < lat; d++) begin
                rde[idx] = 0; ra[idx] = 0; rb[idx] = 0; rt[idx] = 0; rs[idx] = s;
                idx++;
            end
        end
        for (int i = total; i <= total + 1; i++) begin
            rde[i] = 0; ra[i] = 0; rb[i] = 0; rt[i] = 0; rs[i] = 0;
        end
        for (int i = 0; i <= total + 1; i++) begin
            wr = 0; wa = 0; wb = 0;
            if (i >= lat) begin
                wr = rde[i-lat]; wa = ra[i-lat]; wb = rb[i-lat];
            end
            exp_q.push_back(pack_exp(rde[i], ra[i], rb[i], rt[i], rs[i],
                                     (i <= total) ? 1 : 0, (i == total) ? 1 : 0,
                                     wr, wa, wb));
        end
    endtask

    // Entered 1 time unit after a rising edge with the selected DUT idle.
    task automatic run_check(input int n, input int lat, input int plen);
        logic [EW-1:0] e;
        int i, first_done, pending, last_stage;
        build_expected(n, lat);
        set_start(1'b1);
        @(posedge clk); #1;
        i = 0; first_done = -1; pending = 0; last_stage = -1;
        while (exp_q.size() > 0) begin
            if (i >= plen - 1) set_start(1'b0);
            sample_outs();
            e = exp_q.pop_front();
            check("rd_en", m_rd, int'(e[57]));
            check("rd_addr_a", m_ra, int'(e[56:47]));
            check("rd_addr_b", m_rb, int'(e[46:37]));
            check("tw_addr", m_tw, int'(e[36:27]));
            check("stage", m_stg, int'(e[26:23]));
            check("busy", m_busy, int'(e[22]));
            check("done", m_done, int'(e[21]));
            check("wr_en", m_wr, int'(e[20]));
            check("wr_addr_a", m_wa, int'(e[19:10]));
            check("wr_addr_b", m_wb, int'(e[9:0]));
            if (m_done == 1 && first_done < 0) first_done = i;
            if (m_wr == 1) pending--;
            if (m_rd == 1) begin
                if (last_stage >= 0 && m_stg != last_stage) begin
                    check("raw_hazard", pending, 0);
                    assert (pending == 0) else $error("FAIL raw_hazard_assert pending=%0d", pending);
                end
                last_stage = m_stg;
                pending++;
            end
            i++;
            if (exp_q.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        set_start(1'b0);
        // cycle T+1 is the one right after the accepting edge T
        check("latency", first_done + 1, $clog2(n) * (n / 2 + lat) + 1);
    endtask

    task automatic idle_gap();
        int g;
        g = $urandom_range(0, 3);
        for (int c = 0; c < g; c++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic start_hold_test();
        int done_cnt, b2b, rises, rise2, gap, prev_done, prev_busy;
        done_cnt = 0; b2b = 0; rises = 0; rise2 = -1; gap = 0; prev_done = 0; prev_busy = 0;
        sel = 0;
        set_start(1'b1);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            sample_outs();
            if (m_busy == 1 && prev_busy == 0) begin
                rises++;
                if (rises == 2) begin
                    rise2 = c;
                    set_start(1'b0);
                end
            end
            if (m_done == 1) begin
                if (prev_done == 1) b2b++;
                done_cnt++;
            end
            if (done_cnt == 1 && m_busy == 0) gap++;
            prev_done = m_done;
            prev_busy = m_busy;
        end
        set_start(1'b0);
        check("hold_done_count", done_cnt, 2);
        check("hold_done_b2b", b2b, 0);
        check("hold_idle_gap", gap, 1);
        check("hold_second_accept", rise2, 3 * (8 / 2 + 1) + 2);
    endtask

    task automatic reset_mid(input int s_sel, input int n, input int lat, input int r);
        int wr_seen, busy_seen;
        sel = s_sel;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        for (int c = 0; c < r; c++) begin
            @(posedge clk); #1;
        end
        sample_outs();
        check("pre_rst_stage", m_stg, r / (n / 2 + lat));
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        wr_seen = 0; busy_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            sample_outs();
            wr_seen += m_wr;
            busy_seen += m_busy;
        end
        check("post_rst_wr_en", wr_seen, 0);
        check("post_rst_busy", busy_seen, 0);
    endtask

    // RAM + ROM + butterfly around dut8, evaluated mid-cycle.
    int ram_re[8], ram_im[8];
    int rom_re[4], rom_im[4];
    int x1r, x1i, x2r, x2i, wre, wim, dr, di;

    always @(negedge clk) begin
        if (wr8) begin
            dr = x1r - x2r;
            di = x1i - x2i;
            ram_re[wa8] = x1r + x2r;
            ram_im[wa8] = x1i + x2i;
            ram_re[wb8] = (dr * wre - di * wim) >>> 10;
            ram_im[wb8] = (dr * wim + di * wre) >>> 10;
        end
        if (rd8) begin
            x1r = ram_re[ra8]; x1i = ram_im[ra8];
            x2r = ram_re[rb8]; x2i = ram_im[rb8];
            wre = rom_re[tw8]; wim = rom_im[tw8];
        end
    end

    task automatic e2e(input int mode);
        int c, exp_re;
        sel = 0;
        for (int a = 0; a < 8; a++) begin
            ram_re[a] = (mode == 0) ? ((a == 0) ? 512 : 0) : 64;
            ram_im[a] = 0;
        end
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        c = 0;
        sample_outs();
        while (m_done == 0 && c < 100) begin
            @(posedge clk); #1;
            sample_outs();
            c++;
        end
        check("e2e_done_seen", m_done, 1);
        @(posedge clk); #1;
        for (int a = 0; a < 8; a++) begin
            exp_re = (mode == 0) ? 512 : ((a == 0) ? 512 : 0);
            check($sformatf("e2e%0d_re%0d", mode, a), ram_re[a], exp_re);
            check($sformatf("e2e%0d_im%0d", mode, a), ram_im[a], 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rom_re[0] = TW_ONE; rom_im[0] = 0;
        rom_re[1] = 724;    rom_im[1] = -724;
        rom_re[2] = 0;      rom_im[2] = -TW_ONE;
        rom_re[3] = -724;   rom_im[3] = -724;
        rst_n = 1'b0;
        start8 = 1'b0;
        start16 = 1'b0;
        #12;
        sel = 0; check_all_zero("reset8");
        sel = 1; check_all_zero("reset16");
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        sel = 0; run_check(8, 1, 1);
        idle_gap();
        sel = 0; run_check(8, 1, $urandom_range(1, 3));
        idle_gap();
        sel = 1; run_check(16, 3, 1);
        idle_gap();
        sel = 1; run_check(16, 3, $urandom_range(1, 3));
        idle_gap();

        start_hold_test();
        idle_gap();

        reset_mid(0, 8, 1, 7);
        sel = 0; run_check(8, 1, 1);
        idle_gap();
        reset_mid(1, 16, 3, $urandom_range(1, 40));
        sel = 1; run_check(16, 3, 1);
        idle_gap();

        e2e(0);
        idle_gap();
        e2e(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
